controlador_interrupcao_quantum: RTL and testbench
==================================================

Name: controlador_interrupcao_quantum

Overview:
Interrupt requester that sits on the other side of the control unit's intr/inta/clearIntr handshake. It watches the mode pulses the control unit emits (userMode for exec/exec_again, kernelMode for syscall, isHalt), an external I/O request line, and a preemption quantum timer. While a user program runs, it raises intr, latches an interrupt code and the interrupted PC, and holds them for the kernel to read with gic/gip until cic clears them.

Parameters:
QUANTUM, 1000, user-mode cycles allowed before a timer interrupt
CNT_W, 16, quantum counter width; must satisfy QUANTUM <= 2^CNT_W
ADDR_W, 32, PC width

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
userMode  in  1  1-cycle pulse: exec/exec_again decoded, enter user mode
kernelMode  in  1  1-cycle pulse: syscall decoded
isHalt  in  1  halt decoded
ioReq  in  1  external I/O request, level; rising edge detected internally
inta  in  1  interrupt acknowledge from control unit
clearIntr  in  1  cic decoded
pc  in  ADDR_W  PC of the instruction currently executing
intr  out  1  interrupt request to control unit
intrCode  out  6  latched interrupt code (gic source)
intrPC  out  ADDR_W  latched interrupted PC (gip source)
inUser  out  1  1 while in user mode (state USER)

Behaviour:
- Interrupt codes: 0 none, 1 timer quantum, 2 I/O, 3 syscall, 4 halt in user mode.
- States: KERNEL, USER, PENDING, SERVICE.
- Reset, asynchronous: state=KERNEL; intr=0; intrCode=0; intrPC=0; counter=0; ioPending=0; ioReq edge register=0; inUser=0.
- ioPending: set on any ioReq rising edge in any state; cleared only when code 2 is latched.
- KERNEL: kernel is not preemptible; counter holds; no event latched.
  - userMode=1 -> USER next cycle; counter <= QUANTUM-1.
  - kernelMode and isHalt are ignored.
- USER: inUser=1; counter decrements by 1 per cycle.
  - Event sampled each cycle, priority kernelMode > isHalt > ioPending > counter==0.
  - On event: intrCode <= code; intrPC <= pc (same cycle's value); go to PENDING.
  - Lower-priority sources in the same cycle are dropped, except ioPending, which stays set.
  - Counter never wraps: at 0 the timer event fires that cycle and the counter is not decremented.
  - A pre-existing ioPending fires on the first USER cycle, after the userMode pulse.
  - userMode while in USER reloads the counter and is not an event.
- PENDING: intr=1, held until inta is sampled 1.
  - inta=1 -> SERVICE next cycle; intr=0 from that cycle.
  - Other events in PENDING are ignored, except ioReq edges, which set ioPending.
- SERVICE: intr=0; intrCode and intrPC are held stable for gic/gip.
  - clearIntr=1 -> KERNEL; intrCode <= 0 (intrPC is retained).
  - userMode=1 without clearIntr: implicit clear (intrCode <= 0), go straight to USER, counter <= QUANTUM-1.
- Latency: event cycle N -> intr=1 in cycle N+1; inta in cycle M -> intr=0 in cycle M+1.
- inta while not in PENDING is ignored; the control unit drives inta for pre_io as well.
- clearIntr outside SERVICE: intrCode <= 0, state unchanged.
- Reset mid-operation: all state is lost immediately; a pending interrupt is discarded, including ioPending.

Test Plan:
- Timer preemption: QUANTUM=8, reset, userMode pulse with pc=0x40 sequence -> intr=1 exactly 9 cycles after the pulse; intrCode=1; intrPC = pc of the 8th USER cycle. Then inta -> intr=0 next cycle; clearIntr -> intrCode=0, inUser=0.
- Priority: in USER, assert kernelMode, isHalt and ioReq edge in the same cycle -> intrCode=3. After clear and re-entry, ioPending fires on the first USER cycle -> intrCode=2.
- Kernel non-preemptible: ioReq edge and isHalt while in KERNEL -> intr stays 0. Next userMode -> intr=1 with intrCode=2 one cycle after entering USER.
- Handshake hold: hold inta=0 for 20 cycles in PENDING with timer and halt activity -> intr held 1, intrCode unchanged. Then inta -> SERVICE.
- Implicit clear: in SERVICE, pulse userMode (exec_again) -> intrCode=0, inUser=1, counter=QUANTUM-1; timer expires after a full quantum.
- Async reset in PENDING -> intr, intrCode and inUser are 0 immediately, before the next clk edge.

Source files
------------

// File: rtl/controlador_interrupcao_quantum_if.sv
// controlador_interrupcao_quantum_if: control-unit <-> interrupt requester handshake bundle
interface controlador_interrupcao_quantum_if #(parameter int ADDR_W = 32);
  logic              userMode;
  logic              kernelMode;
  logic              isHalt;
  logic              ioReq;
  logic              inta;
  logic              clearIntr;
  logic [ADDR_W-1:0] pc;
  logic              intr;
  logic [5:0]        intrCode;
  logic [ADDR_W-1:0] intrPC;
  logic              inUser;
  modport master (
    output userMode, kernelMode, isHalt, ioReq, inta, clearIntr, pc,
    input  intr, intrCode, intrPC, inUser
  );
  modport slave (
    input  userMode, kernelMode, isHalt, ioReq, inta, clearIntr, pc,
    output intr, intrCode, intrPC, inUser
  );
endinterface

// File: rtl/controlador_interrupcao_quantum.sv
// controlador_interrupcao_quantum: preemption-quantum / IO / syscall / halt interrupt requester
module controlador_interrupcao_quantum #(
  parameter int QUANTUM = 1000,
  parameter int CNT_W   = 16,
  parameter int ADDR_W  = 32
) (
  input logic clk,
  input logic reset,
  controlador_interrupcao_quantum_if.slave bus
);
  typedef enum logic [1:0] {KERNEL, USER, PENDING, SERVICE} state_t;
  state_t            state, state_n;
  logic [CNT_W-1:0]  counter;
  logic              io_q, io_pending, io_edge, event_hit, reload;
  logic [5:0]        event_code, intr_code;
  logic [ADDR_W-1:0] intr_pc;
  assign io_edge = bus.ioReq & ~io_q;
  // user-mode event selection, highest priority first; a zero counter is the quantum expiry
  always_comb begin
    event_code = bus.kernelMode ? 6'd3 : bus.isHalt ? 6'd4 : io_pending ? 6'd2 : counter == '0 ? 6'd1 : 6'd0;
    event_hit  = state == USER && event_code != 6'd0;
    reload     = bus.userMode && !event_hit && state != PENDING && !(state == SERVICE && bus.clearIntr);
  end
  // state register
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= KERNEL;
    else state <= state_n;
  // next-state: kernel is never preempted, only userMode leaves it
  always_comb
    state_n = state == KERNEL  ? (bus.userMode ? USER : KERNEL) :
              state == USER    ? (event_hit ? PENDING : USER) :
              state == PENDING ? (bus.inta ? SERVICE : PENDING) :
              bus.clearIntr    ? KERNEL : bus.userMode ? USER : SERVICE;
  // outputs decoded from state only, so reset clears them immediately
  always_comb begin
    bus.intr   = state == PENDING;
    bus.inUser = state == USER;
  end
  assign bus.intrCode = intr_code;
  assign bus.intrPC   = intr_pc;
  // quantum counter, io edge/pending tracking and latched interrupt code/pc
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      counter    <= '0;
      io_q       <= 1'b0;
      io_pending <= 1'b0;
      intr_code  <= '0;
      intr_pc    <= '0;
    end else begin
      io_q       <= bus.ioReq;
      io_pending <= io_edge | (io_pending & ~(event_hit && event_code == 6'd2));
      if (reload) counter <= CNT_W'(QUANTUM - 1);
      else if (state == USER && !event_hit) counter <= counter - CNT_W'(1);
      if (event_hit) begin
        intr_code <= event_code;
        intr_pc   <= bus.pc;
      end else if (bus.clearIntr || (state == SERVICE && bus.userMode)) intr_code <= '0;
    end
endmodule

// File: tb/tb_controlador_interrupcao_quantum.sv
// tb_controlador_interrupcao_quantum: randomized scoreboard bench against a behavioural model
module tb_controlador_interrupcao_quantum;
  localparam int Q = 8;
  typedef struct packed {
    logic        intr;
    logic [5:0]  code;
    logic [31:0] pc;
    logic        user;
  } obs_t;
  logic clk, reset, io_lvl;
  int   vectors = 0, miscompares = 0, cyc = 0;
  obs_t q[$];
  string       m_mode;
  int          m_left;
  bit          m_pend, m_prev;
  logic [5:0]  m_code;
  logic [31:0] m_pc;
  controlador_interrupcao_quantum_if #(.ADDR_W(32)) bus();
  controlador_interrupcao_quantum #(.QUANTUM(Q), .CNT_W(4), .ADDR_W(32)) dut (
    .clk(clk), .reset(reset), .bus(bus.slave)
  );
  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1);
  end
  task automatic model_update();
    int ev;
    bit io_rise;
    string cur;
    if (reset) begin
      m_mode = "kernel"; m_left = 0; m_pend = 0; m_prev = 0; m_code = 0; m_pc = 0;
      return;
    end
    cur = m_mode;
    io_rise = bus.ioReq && !m_prev;
    m_prev = bus.ioReq;
    ev = 0;
    if (cur == "user") ev = bus.kernelMode ? 3 : bus.isHalt ? 4 : m_pend ? 2 : (m_left == 0) ? 1 : 0;
    if (ev != 0) begin
      m_code = 6'(ev);
      m_pc = bus.pc;
    end else if (bus.clearIntr || (cur == "service" && bus.userMode)) m_code = 0;
    m_pend = io_rise || (m_pend && ev != 2);
    if (cur == "kernel") begin
      if (bus.userMode) begin m_mode = "user"; m_left = Q - 1; end
    end else if (cur == "user") begin
      if (ev != 0) m_mode = "pending";
      else m_left = bus.userMode ? Q - 1 : m_left - 1;
    end else if (cur == "pending") begin
      if (bus.inta) m_mode = "service";
    end else begin
      if (bus.clearIntr) m_mode = "kernel";
      else if (bus.userMode) begin m_mode = "user"; m_left = Q - 1; end
    end
  endtask
  function automatic obs_t expected();
    obs_t e;
    e.intr = (m_mode == "pending");
    e.code = m_code;
    e.pc = m_pc;
    e.user = (m_mode == "user");
    return e;
  endfunction
  task automatic step(input logic um, km, hl, io, ia, ci, input logic [31:0] p);
    bus.userMode = um; bus.kernelMode = km; bus.isHalt = hl; bus.ioReq = io;
    bus.inta = ia; bus.clearIntr = ci; bus.pc = p;
    @(posedge clk);
    model_update();
    q.push_back(expected());
    #1;
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, $urandom);
  endtask
  task automatic run_until_pending(input string tag);
    int i = 0;
    while (m_mode != "pending" && i < 40) begin
      step(0, 0, 0, 0, 0, 0, $urandom);
      i++;
    end
    vectors++;
    if (m_mode != "pending") begin
      miscompares++;
      $display("FAIL %s: got no interrupt within 40 cycles, want pending", tag);
    end
  endtask
  always @(negedge clk) begin
    cyc++;
    if (q.size() != 0) begin
      obs_t e, g;
      e = q.pop_front();
      g = {bus.intr, bus.intrCode, bus.intrPC, bus.inUser};
      vectors++;
      if (g !== e) begin
        miscompares++;
        $display("FAIL cycle %0d outputs: got intr=%0b code=%0d pc=%h user=%0b, want intr=%0b code=%0d pc=%h user=%0b",
                 cyc, g.intr, g.code, g.pc, g.user, e.intr, e.code, e.pc, e.user);
      end
    end
  end
  initial begin
    int n;
    reset = 1; io_lvl = 0;
    idle(2);
    reset = 0;
    idle(2);
    step(1, 0, 0, 0, 0, 0, 32'h40);
    n = 1;
    while (!bus.intr && n < 20) begin
      step(0, 0, 0, 0, 0, 0, 32'h40 + 4 * n);
      n++;
    end
    vectors++;
    if (n != Q + 1) begin
      miscompares++;
      $display("FAIL timer_latency: got %0d cycles, want %0d", n, Q + 1);
    end
    step(0, 0, 0, 0, 1, 0, 32'h0);
    idle(1);
    step(0, 0, 0, 0, 0, 1, 32'h0);
    idle(1);
    step(1, 0, 0, 0, 0, 0, 32'h100);
    step(0, 1, 1, 1, 0, 0, 32'h104);
    step(0, 0, 0, 1, 0, 0, 32'h108);
    step(0, 0, 0, 1, 1, 0, 32'h10c);
    step(0, 0, 0, 0, 0, 1, 32'h110);
    step(1, 0, 0, 0, 0, 0, 32'h114);
    idle(3);
    step(0, 0, 0, 0, 1, 0, 32'h0);
    step(0, 0, 0, 0, 0, 1, 32'h0);
    step(0, 0, 1, 1, 0, 0, 32'h200);
    idle(3);
    step(1, 0, 0, 0, 0, 0, 32'h204);
    idle(2);
    step(0, 0, 0, 0, 1, 0, 32'h0);
    step(0, 0, 0, 0, 0, 1, 32'h0);
    step(1, 0, 0, 0, 0, 0, 32'h300);
    run_until_pending("hold_entry");
    for (int i = 0; i < 20; i++) step($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1), 0, 0, 0, $urandom);
    step(0, 0, 0, 0, 1, 0, 32'h0);
    idle(2);
    step(1, 0, 0, 0, 0, 0, 32'h400);
    run_until_pending("implicit_clear");
    step(0, 0, 0, 0, 1, 0, 32'h0);
    step(0, 0, 0, 0, 0, 1, 32'h0);
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 9) == 0) io_lvl = ~io_lvl;
      step($urandom_range(0, 9) == 0, $urandom_range(0, 19) == 0, $urandom_range(0, 19) == 0,
           io_lvl, $urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0, $urandom);
    end
    n = 0;
    while (m_mode != "kernel" && n < 10) begin
      step(0, 1, 0, 0, 1, 1, $urandom);
      n++;
    end
    step(1, 0, 0, 0, 0, 0, 32'h500);
    run_until_pending("reset_entry");
    bus.userMode = 0; bus.kernelMode = 0; bus.isHalt = 0; bus.ioReq = 1;
    bus.inta = 0; bus.clearIntr = 0;
    @(negedge clk);
    #1 reset = 1;
    #1;
    vectors++;
    if (bus.intr !== 1'b0 || bus.intrCode !== 6'd0 || bus.inUser !== 1'b0) begin
      miscompares++;
      $display("FAIL async_reset: got intr=%0b code=%0d user=%0b, want 0 0 0", bus.intr, bus.intrCode, bus.inUser);
    end
    @(posedge clk);
    model_update();
    q.push_back(expected());
    #1 reset = 0;
    idle(3);
    step(1, 0, 0, 0, 0, 0, 32'h600);
    idle(3);
    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
